// File: rtl/dmem_pkg.sv
// Shared types and constants for the dmem_ctrl data memory controller.
package dmem_pkg;

  localparam int LANES = 4;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10,
    RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'b00,
    ERR_RANGE  = 2'b01,
    ERR_ALIGN  = 2'b10,
    ERR_PARITY = 2'b11
  } err_code_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_e;

  // Byte lanes touched by an access of the given size at byte offset lo.
  function automatic logic [LANES-1:0] lane_mask(input size_e sz, input logic [1:0] lo);
    logic [LANES-1:0] m;
    case (sz)
      BYTE:    m = 4'b0001 << lo;
      HALF:    m = lo[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Selects the addressed byte/half of a memory word and sign- or zero-extends it.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lo_i,
  input  size_e       size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word_i[{lo_i, 3'b000} +: 8];
    half_v = lo_i[1] ? word_i[31:16] : word_i[15:0];
    case (size_i)
      BYTE:    data_o = {{24{byte_v[7] & ~unsigned_i}}, byte_v};
      HALF:    data_o = {{16{half_v[15] & ~unsigned_i}}, half_v};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Handshaked byte/half/word data memory with range and alignment fault reporting.
// Define DMEM_PARITY_EN to add one even-parity bit per byte lane, checked on loads.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h1001_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_err_o,
  output logic [1:0]            resp_err_code_o
);

  localparam int IDX_W = $clog2(MEMORY_DEPTH);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  state_e                state_q, state_d;
  logic                  accept;
  logic [DATA_WIDTH-1:0] mem_q [MEMORY_DEPTH];
  logic [DATA_WIDTH-1:0] rword_q, wword, load_data;
  logic [ADDR_WIDTH-1:0] offset;
  logic [IDX_W-1:0]      idx;
  logic [LANES-1:0]      lane_en;
  size_e                 req_size, size_q;
  err_code_e             req_err, err_q, fin_err, resp_code_q;
  logic                  range_err, align_err;
  logic                  wr_q, uns_q;
  logic [1:0]            lo_q;
  logic [DATA_WIDTH-1:0] resp_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    if (resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o  = (state_q == IDLE);
    resp_valid_o = (state_q == RESP);
  end

  assign accept = req_valid_i && req_ready_o;

  // Address decode; the subtraction wraps for addresses below BASE_ADDR.
  always_comb begin
    req_size  = size_e'(req_size_i);
    offset    = req_addr_i - BASE_ADDR;
    idx       = offset[IDX_W+1:2];
    range_err = (req_addr_i < BASE_ADDR) || ((offset >> 2) >= ADDR_WIDTH'(MEMORY_DEPTH));
    align_err = (req_size == RSVD) ||
                (req_size == HALF && req_addr_i[0]) ||
                (req_size == WORD && req_addr_i[1:0] != 2'b00);
    req_err   = range_err ? ERR_RANGE : (align_err ? ERR_ALIGN : ERR_NONE);
    lane_en   = lane_mask(req_size, req_addr_i[1:0]);
    case (req_size)
      BYTE:    wword = {4{req_wdata_i[7:0]}};
      HALF:    wword = {2{req_wdata_i[15:0]}};
      default: wword = req_wdata_i;
    endcase
  end

`ifdef DMEM_PARITY_EN
  logic [LANES-1:0] par_q [MEMORY_DEPTH];
  logic [LANES-1:0] rpar_q, lanes_q;
  logic             par_bad;
`endif

  // Array and read word are deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      rword_q <= mem_q[idx];
`ifdef DMEM_PARITY_EN
      rpar_q  <= par_q[idx];
      lanes_q <= lane_en;
`endif
      if (req_write_i && req_err == ERR_NONE) begin
        for (int l = 0; l < LANES; l++) begin
          if (lane_en[l]) begin
            mem_q[idx][8*l +: 8] <= wword[8*l +: 8];
`ifdef DMEM_PARITY_EN
            par_q[idx][l] <= ^wword[8*l +: 8];
`endif
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= 1'b0;
      uns_q  <= 1'b0;
      lo_q   <= 2'b00;
      size_q <= BYTE;
      err_q  <= ERR_NONE;
    end else if (accept) begin
      wr_q   <= req_write_i;
      uns_q  <= req_unsigned_i;
      lo_q   <= req_addr_i[1:0];
      size_q <= req_size;
      err_q  <= req_err;
    end
  end

  dmem_load_align u_align (
    .word_i     (rword_q),
    .lo_i       (lo_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (load_data)
  );

  always_comb begin
    fin_err = err_q;
`ifdef DMEM_PARITY_EN
    par_bad = 1'b0;
    for (int l = 0; l < LANES; l++)
      if (lanes_q[l] && ((^rword_q[8*l +: 8]) != rpar_q[l])) par_bad = 1'b1;
    if (err_q == ERR_NONE && !wr_q && par_bad) fin_err = ERR_PARITY;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_rdata_q <= '0;
      resp_code_q  <= ERR_NONE;
    end else if (state_q == ACCESS) begin
      resp_code_q  <= fin_err;
      resp_rdata_q <= (wr_q || fin_err != ERR_NONE) ? '0 : load_data;
    end
  end

  assign resp_rdata_o    = resp_rdata_q;
  assign resp_err_code_o = resp_code_q;
  assign resp_err_o      = (resp_code_q != ERR_NONE);

endmodule
